display_480p: RTL and testbench

DISPLAY_480P -- requirements
Module: display_480p

---
 rtl/display_pkg.sv | 20 ++
 rtl/display_480p.sv | 103 ++++++++++
 tb/tb_display_480p.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Timing constants for 640x480 at 60 Hz, plus sync polarity encodings and
// the coordinate width shared by the display timing block.
package display_pkg;

  localparam int COORD_W = 10;

  localparam int H_RES_480P  = 640;
  localparam int H_FP_480P   = 16;
  localparam int H_SYNC_480P = 96;
  localparam int H_BP_480P   = 48;

  localparam int V_RES_480P  = 480;
  localparam int V_FP_480P   = 10;
  localparam int V_SYNC_480P = 2;
  localparam int V_BP_480P   = 33;

  localparam logic POL_ACTIVE_LOW  = 1'b0;
  localparam logic POL_ACTIVE_HIGH = 1'b1;

endpackage

// File: rtl/display_480p.sv
// Display timing generator: raster position counters plus registered sync,
// data-enable and line/frame strobes, all aligned to the same sx/sy.
module display_480p
  import display_pkg::*;
#(
  parameter int   H_RES  = H_RES_480P,
  parameter int   H_FP   = H_FP_480P,
  parameter int   H_SYNC = H_SYNC_480P,
  parameter int   H_BP   = H_BP_480P,
  parameter int   V_RES  = V_RES_480P,
  parameter int   V_FP   = V_FP_480P,
  parameter int   V_SYNC = V_SYNC_480P,
  parameter int   V_BP   = V_BP_480P,
  parameter logic H_POL  = POL_ACTIVE_LOW,
  parameter logic V_POL  = POL_ACTIVE_LOW
) (
  input  logic               clk_pix,
  input  logic               rst_pix,
  output logic [COORD_W-1:0] sx,
  output logic [COORD_W-1:0] sy,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               line,
  output logic               frame,
  output logic [15:0]        frame_count
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_RES);
  localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_RES);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_RES + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_RES + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_RES + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_RES + V_FP + V_SYNC);

  logic [COORD_W-1:0] sx_q, sx_d;
  logic [COORD_W-1:0] sy_q, sy_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               de_q, de_d;
  logic               line_q, line_d;
  logic               frame_q, frame_d;
  logic [15:0]        frame_count_q, frame_count_d;

  // Decode every output from the next position so they land with it in one edge.
  always_comb begin
    sx_d = sx_q + 10'd1;
    sy_d = sy_q;
    if (sx_q == H_LAST) begin
      sx_d = '0;
      if (sy_q == V_LAST) begin
        sy_d = '0;
      end else begin
        sy_d = sy_q + 10'd1;
      end
    end

    hsync_d = ((sx_d >= HS_START) && (sx_d < HS_END)) ? H_POL : ~H_POL;
    vsync_d = ((sy_d >= VS_START) && (sy_d < VS_END)) ? V_POL : ~V_POL;
    de_d    = (sx_d < H_ACT) && (sy_d < V_ACT);
    line_d  = (sx_d == 10'd0);
    frame_d = (sx_d == 10'd0) && (sy_d == 10'd0);
    frame_count_d = frame_d ? (frame_count_q + 16'd1) : frame_count_q;

    // Parking at the last position makes the first post-reset edge land on (0,0).
    if (rst_pix) begin
      sx_d          = H_LAST;
      sy_d          = V_LAST;
      hsync_d       = ~H_POL;
      vsync_d       = ~V_POL;
      de_d          = 1'b0;
      line_d        = 1'b0;
      frame_d       = 1'b0;
      frame_count_d = 16'd0;
    end
  end

  always_ff @(posedge clk_pix) begin
    sx_q          <= sx_d;
    sy_q          <= sy_d;
    hsync_q       <= hsync_d;
    vsync_q       <= vsync_d;
    de_q          <= de_d;
    line_q        <= line_d;
    frame_q       <= frame_d;
    frame_count_q <= frame_count_d;
  end

  assign sx          = sx_q;
  assign sy          = sy_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign line        = line_q;
  assign frame       = frame_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_display_480p.sv
// Directed bench: a default-timing instance for reset and line checks, and a
// reduced-timing instance (16x12 raster) for frame-level, wrap and reset checks.
module tb_display_480p;

  logic clk_pix = 1'b0;
  logic rst_a;
  logic rst_b;

  logic [9:0]  sx_a, sy_a, sx_b, sy_b;
  logic        hsync_a, vsync_a, de_a, line_a, frame_a;
  logic        hsync_b, vsync_b, de_b, line_b, frame_b;
  logic [15:0] fc_a, fc_b;

  int n_assert = 0;
  int n_fail   = 0;

  always #20 clk_pix = ~clk_pix;

  display_480p dut_a (
    .clk_pix(clk_pix), .rst_pix(rst_a), .sx(sx_a), .sy(sy_a),
    .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .line(line_a),
    .frame(frame_a), .frame_count(fc_a)
  );

  // H: 8 active, 2 fp, 3 sync (sx 10..12), 3 bp; V: 6 active, 2 fp, 2 sync (sy 8..9), 2 bp.
  display_480p #(
    .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_RES(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .H_POL(1'b1), .V_POL(1'b0)
  ) dut_b (
    .clk_pix(clk_pix), .rst_pix(rst_b), .sx(sx_b), .sy(sy_b),
    .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .line(line_b),
    .frame(frame_b), .frame_count(fc_b)
  );

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_b(input string tag);
    check({tag, "_sx"}, 32'(sx_b), 32'd15);
    check({tag, "_sy"}, 32'(sy_b), 32'd11);
    check({tag, "_de"}, 32'(de_b), 32'd0);
    check({tag, "_line"}, 32'(line_b), 32'd0);
    check({tag, "_frame"}, 32'(frame_b), 32'd0);
    check({tag, "_fc"}, 32'(fc_b), 32'd0);
    check({tag, "_hs"}, 32'(hsync_b), 32'd0);
    check({tag, "_vs"}, 32'(vsync_b), 32'd1);
  endtask

  initial begin
    int hs_cnt, hs_first, de_cnt, ln_cnt, vs_high;
    int vs_cnt, vs_first_x, vs_first_y, fr_cnt, hs_b_cnt;

    rst_a = 1'b1;
    rst_b = 1'b1;
    adv(3);

    // Default instance held in reset.
    check("a_rst_sx", 32'(sx_a), 32'd799);
    check("a_rst_sy", 32'(sy_a), 32'd524);
    check("a_rst_de", 32'(de_a), 32'd0);
    check("a_rst_line", 32'(line_a), 32'd0);
    check("a_rst_frame", 32'(frame_a), 32'd0);
    check("a_rst_fc", 32'(fc_a), 32'd0);
    check("a_rst_hs", 32'(hsync_a), 32'd1);
    check("a_rst_vs", 32'(vsync_a), 32'd1);
    check_reset_b("b_rst");

    // First edge after release.
    rst_a = 1'b0;
    tick();
    check("a_rel_sx", 32'(sx_a), 32'd0);
    check("a_rel_sy", 32'(sy_a), 32'd0);
    check("a_rel_de", 32'(de_a), 32'd1);
    check("a_rel_line", 32'(line_a), 32'd1);
    check("a_rel_frame", 32'(frame_a), 32'd1);
    check("a_rel_fc", 32'(fc_a), 32'd1);

    // One full default line.
    hs_cnt = 0; hs_first = -1; de_cnt = 0; ln_cnt = 0; vs_high = 0;
    for (int i = 0; i < 800; i++) begin
      if (hsync_a == 1'b0) begin
        if (hs_first < 0) hs_first = int'(sx_a);
        hs_cnt++;
      end
      if (de_a) de_cnt++;
      if (line_a) ln_cnt++;
      if (vsync_a) vs_high++;
      tick();
    end
    check("a_hs_cycles", 32'(hs_cnt), 32'd96);
    check("a_hs_start", 32'(hs_first), 32'd656);
    check("a_de_cycles", 32'(de_cnt), 32'd640);
    check("a_line_cnt", 32'(ln_cnt), 32'd1);
    check("a_vs_idle", 32'(vs_high), 32'd800);
    check("a_line1_sx", 32'(sx_a), 32'd0);
    check("a_line1_sy", 32'(sy_a), 32'd1);
    check("a_line1_strobe", 32'(line_a), 32'd1);
    check("a_line1_de", 32'(de_a), 32'd1);

    // Reduced instance: release and run one whole frame (16*12 = 192 cycles).
    rst_b = 1'b0;
    tick();
    check("b_rel_sx", 32'(sx_b), 32'd0);
    check("b_rel_sy", 32'(sy_b), 32'd0);
    check("b_rel_frame", 32'(frame_b), 32'd1);
    check("b_rel_fc", 32'(fc_b), 32'd1);
    check("b_rel_de", 32'(de_b), 32'd1);

    vs_cnt = 0; vs_first_x = -1; vs_first_y = -1; fr_cnt = 0; hs_b_cnt = 0;
    for (int i = 0; i < 192; i++) begin
      if (vsync_b == 1'b0) begin
        if (vs_first_x < 0) begin
          vs_first_x = int'(sx_b);
          vs_first_y = int'(sy_b);
        end
        vs_cnt++;
      end
      if (frame_b) fr_cnt++;
      if (hsync_b) hs_b_cnt++;
      tick();
    end
    check("b_vs_cycles", 32'(vs_cnt), 32'd32);
    check("b_vs_start_x", 32'(vs_first_x), 32'd0);
    check("b_vs_start_y", 32'(vs_first_y), 32'd8);
    check("b_frame_once", 32'(fr_cnt), 32'd1);
    check("b_hs_high_cycles", 32'(hs_b_cnt), 32'd36);
    check("b_period_frame", 32'(frame_b), 32'd1);
    check("b_period_sx", 32'(sx_b), 32'd0);
    check("b_period_sy", 32'(sy_b), 32'd0);
    check("b_fc_two", 32'(fc_b), 32'd2);

    // Wrap out of the last active line: (15,5) -> (0,6).
    adv(95);
    check("b_w1_sx", 32'(sx_b), 32'd15);
    check("b_w1_sy", 32'(sy_b), 32'd5);
    tick();
    check("b_w1n_sx", 32'(sx_b), 32'd0);
    check("b_w1n_sy", 32'(sy_b), 32'd6);
    check("b_w1n_de", 32'(de_b), 32'd0);
    check("b_w1n_line", 32'(line_b), 32'd1);

    // Frame wrap: (15,11) -> (0,0).
    adv(95);
    check("b_w2_sx", 32'(sx_b), 32'd15);
    check("b_w2_sy", 32'(sy_b), 32'd11);
    check("b_w2_frame", 32'(frame_b), 32'd0);
    tick();
    check("b_w2n_sx", 32'(sx_b), 32'd0);
    check("b_w2n_sy", 32'(sy_b), 32'd0);
    check("b_w2n_frame", 32'(frame_b), 32'd1);
    check("b_w2n_fc", 32'(fc_b), 32'd3);

    // Mid-frame reset at (5,3) held for 3 cycles.
    adv(53);
    check("b_mid_sx", 32'(sx_b), 32'd5);
    check("b_mid_sy", 32'(sy_b), 32'd3);
    rst_b = 1'b1;
    tick();
    check_reset_b("b_mrst1");
    tick();
    tick();
    check_reset_b("b_mrst3");
    rst_b = 1'b0;
    tick();
    check("b_mrel_sx", 32'(sx_b), 32'd0);
    check("b_mrel_sy", 32'(sy_b), 32'd0);
    check("b_mrel_frame", 32'(frame_b), 32'd1);
    check("b_mrel_fc", 32'(fc_b), 32'd1);

    // Counter wrap: preload 65535, next frame strobe must read 0.
    adv(10);
    force dut_b.frame_count_q = 16'hFFFF;
    #1;
    release dut_b.frame_count_q;
    #1;
    check("b_fc_preload", 32'(fc_b), 32'd65535);
    adv(182);
    check("b_fcw_frame", 32'(frame_b), 32'd1);
    check("b_fcw_fc", 32'(fc_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
